// File: rtl/screen_fetch_seq_if.sv
// Bundle between the fetch sequencer and its surroundings: cell timing inputs,
// the VRAM request/return path, and the captured cell handed to the shifter.
interface screen_fetch_seq_if;
  logic        cell_strobe;
  logic        fetch_window;
  logic [4:0]  col;
  logic [7:0]  line;
  logic        up_en;
  logic [7:0]  vd;

  logic        screen_fetch;
  logic        screen_fetch_up;
  logic [14:0] screen_addr;
  logic [5:0]  screen_up_addr;

  logic [7:0]  bitmap;
  logic [7:0]  attr;
  logic [7:0]  ink_rgb;
  logic [7:0]  paper_rgb;
  logic        cell_valid;
  logic        overrun;

  // Sequencer side
  modport master (
    input  cell_strobe, fetch_window, col, line, up_en, vd,
    output screen_fetch, screen_fetch_up, screen_addr, screen_up_addr,
    output bitmap, attr, ink_rgb, paper_rgb, cell_valid, overrun
  );

  // Video timing generator / memory controller / shifter side
  modport slave (
    output cell_strobe, fetch_window, col, line, up_en, vd,
    input  screen_fetch, screen_fetch_up, screen_addr, screen_up_addr,
    input  bitmap, attr, ink_rgb, paper_rgb, cell_valid, overrun
  );
endinterface

// File: rtl/screen_fetch_seq.sv
// Per-cell VRAM fetch sequencer: bitmap, attribute and optional ULA+ ink/paper
// reads, captured into shadows and published to the pixel shifter in one cycle.
//
// state | meaning
// IDLE  | waiting for cell_strobe inside the paper area
// BMP   | bitmap byte fetch
// ATR   | attribute byte fetch
// UPI   | ULA+ ink palette entry fetch
// UPP   | ULA+ paper palette entry fetch
// DONE  | publish shadows, pulse cell_valid
module screen_fetch_seq #(
  parameter int FETCH_LEN = 4,
  parameter int LATCH_AT  = 3
) (
  input logic                clk28,
  input logic                rst_n,
  screen_fetch_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BMP  = 3'd1,
    ATR  = 3'd2,
    UPI  = 3'd3,
    UPP  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Phase is a down-counter: loaded on state entry, terminal count at zero.
  localparam logic [1:0] PH_LOAD  = 2'(FETCH_LEN - 1);
  localparam logic [1:0] PH_LATCH = 2'(FETCH_LEN - 1 - LATCH_AT);

  state_t      state, state_nxt;
  logic [1:0]  ph_cnt, ph_nxt;

  logic [4:0]  col_s;
  logic [7:0]  line_s;
  logic        up_s;

  logic [7:0]  bmp_s;
  logic [7:0]  attr_s;
  logic [7:0]  ink_s;
  logic [7:0]  paper_s;

  logic        start;
  logic        in_fetch;
  logic        ph_tc;
  logic        latch;
  logic [4:0]  col_src;
  logic [7:0]  line_src;
  logic [7:0]  attr_fwd;

  logic        fetch_nxt;
  logic        fetch_up_nxt;
  logic [14:0] addr_nxt;
  logic [5:0]  up_addr_nxt;

  logic        fetch_q;
  logic        fetch_up_q;
  logic [14:0] addr_q;
  logic [5:0]  up_addr_q;
  logic [7:0]  bitmap_q;
  logic [7:0]  attr_q;
  logic [7:0]  ink_q;
  logic [7:0]  paper_q;
  logic        cell_valid_q;
  logic        overrun_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ph_cnt <= 2'd0;
    end else begin
      state  <= state_nxt;
      ph_cnt <= ph_nxt;
    end
  end

  always_comb begin
    start    = (state == IDLE) && bus.cell_strobe && bus.fetch_window;
    in_fetch = (state == BMP) || (state == ATR) || (state == UPI) || (state == UPP);
    ph_tc    = (ph_cnt == 2'd0);
    latch    = in_fetch && (ph_cnt == PH_LATCH);

    // Addresses are registered from the next state, so the entering cycle must
    // see the values being latched on that same edge.
    col_src  = (state == IDLE) ? bus.col  : col_s;
    line_src = (state == IDLE) ? bus.line : line_s;
    attr_fwd = ((state == ATR) && latch) ? bus.vd : attr_s;

    state_nxt = state;
    ph_nxt    = ph_cnt;
    if (in_fetch) begin
      ph_nxt = ph_tc ? PH_LOAD : ph_cnt - 2'd1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BMP;
          ph_nxt    = PH_LOAD;
        end
      end
      BMP:     if (ph_tc) state_nxt = ATR;
      ATR:     if (ph_tc) state_nxt = up_s ? UPI : DONE;
      UPI:     if (ph_tc) state_nxt = UPP;
      UPP:     if (ph_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    fetch_nxt    = 1'b0;
    fetch_up_nxt = 1'b0;
    addr_nxt     = addr_q;
    up_addr_nxt  = up_addr_q;
    case (state_nxt)
      BMP: begin
        fetch_nxt = 1'b1;
        addr_nxt  = {2'b00, line_src[7:6], line_src[2:0], line_src[5:3], col_src};
      end
      ATR: begin
        fetch_nxt = 1'b1;
        addr_nxt  = {5'b00110, line_src[7:3], col_src};
      end
      UPI: begin
        fetch_nxt    = 1'b1;
        fetch_up_nxt = 1'b1;
        up_addr_nxt  = {attr_fwd[7:6], 1'b0, attr_fwd[2:0]};
      end
      UPP: begin
        fetch_nxt    = 1'b1;
        fetch_up_nxt = 1'b1;
        up_addr_nxt  = {attr_fwd[7:6], 1'b1, attr_fwd[5:3]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      col_s   <= 5'd0;
      line_s  <= 8'd0;
      up_s    <= 1'b0;
      bmp_s   <= 8'd0;
      attr_s  <= 8'd0;
      ink_s   <= 8'd0;
      paper_s <= 8'd0;
    end else begin
      if (start) begin
        col_s  <= bus.col;
        line_s <= bus.line;
        up_s   <= bus.up_en;
      end
      if (latch) begin
        case (state)
          BMP:     bmp_s   <= bus.vd;
          ATR:     attr_s  <= bus.vd;
          UPI:     ink_s   <= bus.vd;
          UPP:     paper_s <= bus.vd;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q      <= 1'b0;
      fetch_up_q   <= 1'b0;
      addr_q       <= 15'd0;
      up_addr_q    <= 6'd0;
      bitmap_q     <= 8'd0;
      attr_q       <= 8'd0;
      ink_q        <= 8'd0;
      paper_q      <= 8'd0;
      cell_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      fetch_q      <= fetch_nxt;
      fetch_up_q   <= fetch_up_nxt;
      addr_q       <= addr_nxt;
      up_addr_q    <= up_addr_nxt;
      cell_valid_q <= (state == DONE);
      if (state == DONE) begin
        bitmap_q <= bmp_s;
        attr_q   <= attr_s;
        if (up_s) begin
          ink_q   <= ink_s;
          paper_q <= paper_s;
        end
      end
      if (bus.cell_strobe && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.screen_fetch    = fetch_q;
  assign bus.screen_fetch_up = fetch_up_q;
  assign bus.screen_addr     = addr_q;
  assign bus.screen_up_addr  = up_addr_q;
  assign bus.bitmap          = bitmap_q;
  assign bus.attr            = attr_q;
  assign bus.ink_rgb         = ink_q;
  assign bus.paper_rgb       = paper_q;
  assign bus.cell_valid      = cell_valid_q;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_screen_fetch_seq.sv
// Bench for screen_fetch_seq: a VRAM/palette model answers fetches, a scoreboard
// of expected cells and fetches is filled at strobe time and drained by a monitor.
module tb_screen_fetch_seq;
  localparam int FETCH_LEN = 4;
  localparam int LATCH_AT  = 3;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  always #18 clk28 = ~clk28;

  screen_fetch_seq_if bus ();

  screen_fetch_seq #(.FETCH_LEN(FETCH_LEN), .LATCH_AT(LATCH_AT)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] bmp;
    logic [7:0] attr;
    logic [7:0] ink;
    logic [7:0] paper;
    int         due;
  } cell_t;

  typedef struct {
    logic up;
    int   addr;
  } fetch_t;

  logic [7:0] vram [0:32767];
  logic [7:0] pal  [0:63];
  cell_t      cq[$];
  fetch_t     fq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int fcnt  = 0;
  int busy_until = -100;
  int ovr_from   = 1 << 30;
  logic [7:0] last_bmp = 8'd0, last_attr = 8'd0, last_ink = 8'd0, last_paper = 8'd0;

  always @(posedge clk28) cyc <= cyc + 1;

  function automatic int bmp_addr(input int c, input int l);
    return (l / 64) * 2048 + (l % 8) * 256 + ((l / 8) % 8) * 32 + c;
  endfunction
  function automatic int atr_addr(input int c, input int l);
    return 6144 + 32 * (l / 8) + c;
  endfunction
  function automatic int ink_idx(input int a);
    return (a / 64) * 16 + (a % 8);
  endfunction
  function automatic int paper_idx(input int a);
    return (a / 64) * 16 + 8 + (a / 8) % 8;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic strobe(input int c, input int l, input bit win, input bit up);
    int     now, len, a;
    cell_t  e;
    fetch_t f;
    @(posedge clk28); #1;
    bus.cell_strobe  = 1'b1;
    bus.fetch_window = win;
    bus.col          = 5'(c);
    bus.line         = 8'(l);
    bus.up_en        = up;
    now = cyc;
    if (now <= busy_until) begin
      if (ovr_from > now + 1) ovr_from = now + 1;
    end else if (win) begin
      len        = up ? 2 + 4 * FETCH_LEN : 2 + 2 * FETCH_LEN;
      busy_until = now + len - 1;
      a          = int'(vram[15'(atr_addr(c, l))]);
      e.bmp      = vram[15'(bmp_addr(c, l))];
      e.attr     = 8'(a);
      if (up) begin
        last_ink   = pal[6'(ink_idx(a))];
        last_paper = pal[6'(paper_idx(a))];
      end
      e.ink   = last_ink;
      e.paper = last_paper;
      e.due   = now + len;
      cq.push_back(e);
      last_bmp  = e.bmp;
      last_attr = e.attr;
      f.up = 1'b0; f.addr = bmp_addr(c, l);  fq.push_back(f);
      f.up = 1'b0; f.addr = atr_addr(c, l);  fq.push_back(f);
      if (up) begin
        f.up = 1'b1; f.addr = ink_idx(a);   fq.push_back(f);
        f.up = 1'b1; f.addr = paper_idx(a); fq.push_back(f);
      end
    end
    @(posedge clk28); #1;
    // Scramble sampled inputs mid-cell; only strobe-time values may matter.
    bus.cell_strobe  = 1'b0;
    bus.fetch_window = 1'($urandom);
    bus.col          = 5'($urandom);
    bus.line         = 8'($urandom_range(0, 191));
    bus.up_en        = 1'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk28);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch"},    int'(bus.screen_fetch),    0);
    check({tag, "_fetch_up"}, int'(bus.screen_fetch_up), 0);
    check({tag, "_addr"},     int'(bus.screen_addr),     0);
    check({tag, "_up_addr"},  int'(bus.screen_up_addr),  0);
    check({tag, "_bitmap"},   int'(bus.bitmap),          0);
    check({tag, "_attr"},     int'(bus.attr),            0);
    check({tag, "_ink"},      int'(bus.ink_rgb),         0);
    check({tag, "_paper"},    int'(bus.paper_rgb),       0);
    check({tag, "_valid"},    int'(bus.cell_valid),      0);
    check({tag, "_overrun"},  int'(bus.overrun),         0);
  endtask

  task automatic model_reset();
    cq.delete();
    fq.delete();
    busy_until = -100;
    ovr_from   = 1 << 30;
    last_bmp   = 8'd0;
    last_attr  = 8'd0;
    last_ink   = 8'd0;
    last_paper = 8'd0;
  endtask

  // Monitor and VRAM responder
  always @(negedge clk28) begin
    cell_t  e;
    fetch_t f;
    if (!rst_n) begin
      fcnt   = 0;
      bus.vd = 8'd0;
    end else begin
      if (bus.cell_valid) begin
        if (cq.size() == 0) begin
          check("spurious_cell_valid", int'(bus.cell_valid), 0);
        end else begin
          e = cq.pop_front();
          check("cell_latency", cyc, e.due);
          check("bitmap", int'(bus.bitmap),    int'(e.bmp));
          check("attr",   int'(bus.attr),      int'(e.attr));
          check("ink",    int'(bus.ink_rgb),   int'(e.ink));
          check("paper",  int'(bus.paper_rgb), int'(e.paper));
        end
      end else if (cq.size() > 0 && cq[0].due < cyc) begin
        check("cell_valid_timeout", int'(bus.cell_valid), 1);
        void'(cq.pop_front());
      end

      check("overrun", int'(bus.overrun), int'(cyc >= ovr_from));

      if (bus.screen_fetch) begin
        if (fq.size() == 0) begin
          check("spurious_fetch", int'(bus.screen_fetch), 0);
          bus.vd = 8'($urandom);
        end else begin
          f = fq[0];
          check("fetch_up", int'(bus.screen_fetch_up), int'(f.up));
          check("fetch_addr", f.up ? int'(bus.screen_up_addr) : int'(bus.screen_addr), f.addr);
          if (fcnt == LATCH_AT)
            bus.vd = bus.screen_fetch_up ? pal[bus.screen_up_addr] : vram[bus.screen_addr];
          else
            bus.vd = 8'($urandom);
          fcnt++;
          if (fcnt == FETCH_LEN) begin
            void'(fq.pop_front());
            fcnt = 0;
          end
        end
      end else begin
        if (fcnt != 0) check("fetch_too_short", int'(bus.screen_fetch), 1);
        fcnt = 0;
        check("fetch_up_idle", int'(bus.screen_fetch_up), 0);
        bus.vd = 8'($urandom);
      end
    end
  end

  initial begin
    #(36 * 90000);
    $display("FAIL global_timeout: bench did not finish, %0d cells pending", cq.size());
    $fatal(1, "timeout");
  end

  initial begin
    bus.cell_strobe  = 1'b0;
    bus.fetch_window = 1'b0;
    bus.col          = 5'd0;
    bus.line         = 8'd0;
    bus.up_en        = 1'b0;
    bus.vd           = 8'd0;
    for (int i = 0; i < 32768; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)    pal[i]  = 8'($urandom);

    gap(3); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    gap(4);

    // Normal cell, no ULA+
    vram[15'h0C85] = 8'h3C;
    vram[15'h1985] = 8'h47;
    strobe(5, 100, 1'b1, 1'b0);
    check("normal_bmp_addr", int'(bus.screen_addr), 'h0C85);
    gap(4); #1;
    check("normal_atr_addr", int'(bus.screen_addr), 'h1985);
    gap(30);

    // Same cell with ULA+
    vram[15'h1985] = 8'hC9;
    pal[6'h31]     = 8'h1F;
    pal[6'h39]     = 8'hE0;
    strobe(5, 100, 1'b1, 1'b1);
    gap(8); #1;
    check("ulap_ink_idx",     int'(bus.screen_up_addr),  'h31);
    check("ulap_ink_fup",     int'(bus.screen_fetch_up), 1);
    gap(4); #1;
    check("ulap_paper_idx",   int'(bus.screen_up_addr),  'h39);
    check("ulap_paper_fup",   int'(bus.screen_fetch_up), 1);
    gap(30);

    // Reset asserted during the attribute fetch
    vram[15'h0000] = 8'hAA;
    vram[15'h1800] = 8'h47;
    strobe(0, 0, 1'b1, 1'b0);
    gap(5); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    gap(2); #1;
    rst_n = 1'b1;
    strobe(17, 77, 1'b1, 1'b0);
    gap(30);

    // Outside the paper area
    strobe(3, 40, 1'b0, 1'b1);
    gap(32); #1;
    check("nowin_bitmap_hold", int'(bus.bitmap), int'(last_bmp));
    check("nowin_attr_hold",   int'(bus.attr),   int'(last_attr));

    // Corner address
    strobe(31, 191, 1'b1, 1'b0);
    check("corner_bmp_addr", int'(bus.screen_addr), 'h17FF);
    gap(4); #1;
    check("corner_atr_addr", int'(bus.screen_addr), 'h1AFF);
    gap(30);

    // Overrun: second strobe six cycles after the first
    strobe(9, 130, 1'b1, 1'b1);
    gap(4);
    strobe(10, 130, 1'b1, 1'b0);
    gap(40);

    // Clear the sticky flag, then random traffic
    @(posedge clk28); #1;
    rst_n = 1'b0;
    model_reset();
    gap(2); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 250; i++) begin
      gap($urandom_range(0, 24));
      strobe($urandom_range(0, 31), $urandom_range(0, 191),
             ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    gap(40);
    check("cells_pending",   cq.size(), 0);
    check("fetches_pending", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
